// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared types and constants for the transport-stream byte assembler
package ts_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_BYTES = 188;

    // Width of a counter able to index every byte of a packet.
    function automatic int ts_cnt_width(input int pkt_bytes);
        return $clog2(pkt_bytes);
    endfunction

    localparam int TS_CNT_W = ts_cnt_width(TS_PKT_BYTES);

    // One FIFO entry: framing flags travel with the data byte.
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } ts_byte_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request and data; a push while full is accepted only if a pop happens too
//   pop, dout     read request and head data; dout reads 0 while empty, pop ignored while empty
//   full, empty   status flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Index plus one wrap bit, so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ts_byte_assembler.sv
// rtl/ts_byte_assembler.sv - packs a serial packet bit stream into framed bytes behind a FIFO
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   bit_in, valid_in, pkt_end_in   serial bits (MSB-first per byte) and end-of-packet strobe
//   byte_out, sop_out, eop_out     FIFO head byte and its framing flags
//   byte_valid, byte_ready         head handshake
//   overflow                       sticky: a completed byte was dropped on a full FIFO
//   sync_err                       one-cycle pulse on any framing error
module ts_byte_assembler
    import ts_pkg::*;
#(
    parameter int         PKT_BYTES  = TS_PKT_BYTES,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = TS_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       valid_in,
    input  logic       pkt_end_in,
    output logic [7:0] byte_out,
    output logic       sop_out,
    output logic       eop_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       overflow,
    output logic       sync_err
);

    localparam int CNT_W = ts_cnt_width(PKT_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_BYTES - 1);

    // Only the seven older bits are stored; the eighth is bit_in itself.
    logic [6:0]       shreg;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] byte_cnt;

    logic [7:0] new_byte;
    logic       byte_done;
    logic       at_first;
    logic       at_last;
    logic       end_ok;
    logic       early_end;
    logic       push;
    logic       missing_end;
    logic       bad_sync;
    logic       drop;

    ts_byte_t   push_word;
    ts_byte_t   head;
    logic       fifo_full;
    logic       fifo_empty;

    assign new_byte  = {shreg, bit_in};
    assign byte_done = valid_in && (bit_cnt == 3'd7);
    assign at_first  = (byte_cnt == '0);
    assign at_last   = (byte_cnt == LAST_BYTE);
    assign end_ok    = byte_done && at_last;

    // An end strobe anywhere but the final bit truncates the packet; that bit is not pushed.
    assign early_end   = valid_in && pkt_end_in && !end_ok;
    assign push        = byte_done && !early_end;
    assign missing_end = push && at_last && !pkt_end_in;
    assign bad_sync    = push && at_first && (new_byte != SYNC_BYTE);
    assign drop        = push && fifo_full && !(byte_ready && !fifo_empty);

    assign push_word.sop  = at_first;
    assign push_word.eop  = at_last;
    assign push_word.data = new_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (valid_in) begin
                if (early_end) begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end else begin
                    shreg   <= new_byte[6:0];
                    bit_cnt <= bit_cnt + 1'b1;
                    if (byte_done) byte_cnt <= at_last ? '0 : byte_cnt + 1'b1;
                end
            end
            // Coincident error sources still give a single pulse.
            sync_err <= early_end || missing_end || bad_sync;
            if (drop) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(ts_byte_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (byte_ready),
        .din   (push_word),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign byte_out   = head.data;
    assign sop_out    = head.sop;
    assign eop_out    = head.eop;
    assign byte_valid = !fifo_empty;

endmodule

// File: tb/tb_ts_byte_assembler.sv
// tb/tb_ts_byte_assembler.sv - scoreboard bench for ts_byte_assembler
module tb_ts_byte_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       valid_in = 1'b0;
    logic       pkt_end_in = 1'b0;
    logic [7:0] byte_out;
    logic       sop_out;
    logic       eop_out;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic       overflow;
    logic       sync_err;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] sb[$];
    logic       exp_err = 1'b0;
    logic       exp_ovf = 1'b0;
    int         m_bit = 0;
    int         m_byte = 0;
    logic [7:0] m_sh = 8'h00;

    always #5 clk = ~clk;

    ts_byte_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .valid_in   (valid_in),
        .pkt_end_in (pkt_end_in),
        .byte_out   (byte_out),
        .sop_out    (sop_out),
        .eop_out    (eop_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .overflow   (overflow),
        .sync_err   (sync_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: runs on the falling edge, well away from the sampling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("sync_err", 32'(sync_err), 32'(exp_err));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            if (byte_valid) begin
                if (byte_ready) begin
                    chk("pop_expected", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) chk("byte", 32'({sop_out, eop_out, byte_out}), 32'(sb.pop_front()));
                end
            end else begin
                chk("idle_head", 32'({sop_out, eop_out, byte_out}), 32'd0);
            end
        end
    end

    // Drive one cycle of input and advance the reference model for it.
    task automatic step(input logic v, input logic b, input logic pe, input logic rdy);
        logic       nerr;
        logic       ndrop;
        logic [7:0] d;
        int         occ;
        logic       pop;
        valid_in   = v;
        bit_in     = b;
        pkt_end_in = pe;
        byte_ready = rdy;
        nerr  = 1'b0;
        ndrop = 1'b0;
        if (v) begin
            d = {m_sh[6:0], b};
            if (pe && !(m_bit == 7 && m_byte == 187)) begin
                nerr   = 1'b1;
                m_bit  = 0;
                m_byte = 0;
            end else begin
                if (m_bit == 7) begin
                    if (m_byte == 0 && d != 8'h47) nerr = 1'b1;
                    if (m_byte == 187 && !pe) nerr = 1'b1;
                    occ = sb.size();
                    pop = rdy && (occ > 0);
                    if (occ == 16 && !pop) ndrop = 1'b1;
                    else sb.push_back({(m_byte == 0), (m_byte == 187), d});
                    m_byte = (m_byte == 187) ? 0 : m_byte + 1;
                end
                m_bit = (m_bit + 1) % 8;
                m_sh  = d;
            end
        end
        @(posedge clk);
        #1;
        exp_err = nerr;
        if (ndrop) exp_ovf = 1'b1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        m_bit   = 0;
        m_byte  = 0;
        m_sh    = 8'h00;
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_err", 32'(sync_err), 32'd0);
        chk("rst_head", 32'({sop_out, eop_out, byte_out}), 32'd0);
    endtask

    function automatic logic [7:0] pkt_byte(input logic [7:0] first, input int i);
        return (i == 0) ? first : 8'(i - 1);
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic pe_last, input logic rdy, input logic gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps && $urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'b0, rdy);
            step(1'b1, d[i], pe_last && (i == 0), rdy);
        end
    endtask

    task automatic send_range(input logic [7:0] first, input int lo, input int hi,
                              input logic with_end, input logic rdy, input logic gaps);
        for (int i = lo; i <= hi; i++)
            send_byte(pkt_byte(first, i), with_end && (i == 187), rdy, gaps);
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (sb.size() == 0) break;
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
        chk("empty_after_drain", 32'(byte_valid), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Clean packet with random idle gaps.
        send_range(8'h47, 0, 187, 1'b1, 1'b1, 1'b1);
        drain();

        // Backpressure: 17 bytes into a 16-deep FIFO, the last one is dropped.
        send_range(8'h47, 0, 16, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_overflow", 32'(overflow), 32'd1);
        drain();
        chk("bp_sticky", 32'(overflow), 32'd1);
        send_range(8'h47, 17, 187, 1'b1, 1'b1, 1'b0);
        drain();

        // Full FIFO with push and pop on the completing cycle.
        do_reset();
        send_range(8'h47, 0, 15, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 1; i--) step(1'b1, pkt_byte(8'h47, 16) >> i, 1'b0, 1'b0);
        step(1'b1, pkt_byte(8'h47, 16) & 8'h01, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        drain();
        send_range(8'h47, 17, 187, 1'b1, 1'b1, 1'b0);
        drain();

        // Early end after byte 100 plus three bits, then a clean packet.
        send_range(8'h47, 0, 100, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("early_err", 32'(sync_err), 32'd1);
        send_range(8'h47, 0, 187, 1'b1, 1'b1, 1'b0);
        drain();

        // Bad sync byte, then a packet whose end strobe is missing.
        send_range(8'h48, 0, 187, 1'b1, 1'b1, 1'b0);
        send_range(8'h47, 0, 187, 1'b0, 1'b1, 1'b0);
        chk("missing_end_err", 32'(sync_err), 32'd1);
        drain();

        // Reset mid-packet, then a clean packet.
        send_range(8'h47, 0, 49, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        send_range(8'h47, 0, 187, 1'b1, 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
